// File: rtl/watch_pkg.sv
// Shared constants, key codes, scanner states and digit helpers for the watch.
package watch_pkg;

  localparam logic [3:0] BLANK      = 4'hF;
  localparam logic [3:0] HH_MAX     = 4'd2;
  localparam logic [3:0] HL_MAX     = 4'd9;
  localparam logic [3:0] HL_MAX_H2  = 4'd3;
  localparam logic [3:0] MS_H_MAX   = 4'd5;
  localparam logic [3:0] MS_L_MAX   = 4'd9;

  // code = col*4 + row, both zero-based
  localparam logic [3:0] KEY_HH      = 4'd1;
  localparam logic [3:0] KEY_HL      = 4'd5;
  localparam logic [3:0] KEY_MH      = 4'd2;
  localparam logic [3:0] KEY_ML      = 4'd6;
  localparam logic [3:0] KEY_SH      = 4'd3;
  localparam logic [3:0] KEY_SL      = 4'd7;
  localparam logic [3:0] KEY_ALEN    = 4'd9;
  localparam logic [3:0] KEY_DISMISS = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_DEB, S_SCAN, S_EMIT, S_REL} scan_state_t;

  // {a..g}, active-high; anything outside 0-9 is dark
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
    wrap_inc = (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Tens-of-hours bump; clamps the ones digit when entering the 20s
  function automatic logic [7:0] inc_hour_h(input logic [3:0] hh, input logic [3:0] hl);
    logic [3:0] nh;
    nh = wrap_inc(hh, HH_MAX);
    inc_hour_h = {nh, ((nh == HH_MAX) && (hl > HL_MAX_H2)) ? HL_MAX_H2 : hl};
  endfunction

  function automatic logic [3:0] inc_hour_l(input logic [3:0] hh, input logic [3:0] hl);
    inc_hour_l = wrap_inc(hl, (hh == HH_MAX) ? HL_MAX_H2 : HL_MAX);
  endfunction

endpackage

// File: rtl/watch_alarm_key_matrix_scan.sv
// 4x4 matrix scanner: debounce press, locate key column by column, one event
// per press, then wait for a debounced release.
module key_matrix_scan
  import watch_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  scan_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_col, w_col;
  logic          r_ph, w_ph;
  logic [3:0]    r_code, w_code;
  logic          w_any_low;
  logic [1:0]    w_row_idx;

  assign w_any_low = ~&key_row;
  assign w_row_idx = !key_row[0] ? 2'd0 : !key_row[1] ? 2'd1 : !key_row[2] ? 2'd2 : 2'd3;

  // State and scan registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= 2'd0;
      r_ph    <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_col   <= w_col;
      r_ph    <= w_ph;
      r_code  <= w_code;
    end
  end

  // Next-state and column drive; all columns low outside SCAN so any key shows
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_col   = r_col;
    w_ph    = r_ph;
    w_code  = r_code;
    key_col = 4'b0000;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (w_any_low) w_next = S_DEB;
      end
      S_DEB: begin
        if (!w_any_low) begin
          w_next = S_IDLE;
          w_cnt  = '0;
        end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          w_next = S_SCAN;
          w_cnt  = '0;
          w_col  = 2'd0;
          w_ph   = 1'b0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_SCAN: begin
        key_col = ~(4'b0001 << r_col);
        // first cycle lets the rows settle, second cycle samples
        if (!r_ph) begin
          w_ph = 1'b1;
        end else begin
          w_ph = 1'b0;
          if (w_any_low) begin
            w_code = {r_col, w_row_idx};
            w_next = S_EMIT;
          end else if (r_col == 2'd3) begin
            w_next = S_IDLE;
          end else begin
            w_col = r_col + 2'd1;
          end
        end
      end
      S_EMIT: begin
        w_next = S_REL;
        w_cnt  = '0;
      end
      S_REL: begin
        if (w_any_low) begin
          w_cnt = '0;
        end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          w_next = S_IDLE;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign key_valid = (r_state == S_EMIT);
  assign key_code  = r_code;

endmodule

// File: rtl/watch_alarm.sv
// Six-digit watch with HH:MM alarm, keypad editing and 12/24-hour display.
module watch_alarm
  import watch_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_SHIFT = 10,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RING_SECS  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       alarm_set,
  input  logic       mode_12h,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [5:0] num0_scan_select,
  output logic [6:0] num0_seg7,
  output logic       pm_led,
  output logic       alarm_out
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = SCAN_SHIFT + 3;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_key_valid;
  logic [3:0]    w_key_code;
  logic [3:0]    r_hh, r_hl, r_mh, r_ml, r_sh, r_sl;
  logic [3:0]    r_ahh, r_ahl, r_amh, r_aml;
  logic [3:0]    w_nhh, w_nhl, w_nmh, w_nml, w_nsh, w_nsl;
  logic          r_alen, r_alarm;
  logic [RW-1:0] r_ring;
  logic          w_trig, w_dismiss, w_alen_tog, w_edit_t, w_edit_a;

  key_matrix_scan #(.DEB_CYCLES(DEB_CYCLES)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (w_key_valid),
    .key_code  (w_key_code)
  );

  assign w_tick     = !set && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_edit_t   = w_key_valid && set && !alarm_set;
  assign w_edit_a   = w_key_valid && set && alarm_set;
  assign w_dismiss  = w_key_valid && (w_key_code == KEY_DISMISS);
  assign w_alen_tog = w_key_valid && (w_key_code == KEY_ALEN);
  assign w_trig     = w_tick && r_alen && ({w_nhh, w_nhl, w_nmh, w_nml} == {r_ahh, r_ahl, r_amh, r_aml})
                      && (w_nsh == 4'd0) && (w_nsl == 4'd0);

  // One-second divider, parked at zero while editing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (set)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Time after one second, full carry chain resolved combinationally
  always_comb begin
    {w_nhh, w_nhl, w_nmh, w_nml, w_nsh, w_nsl} = {r_hh, r_hl, r_mh, r_ml, r_sh, r_sl};
    if (r_sl == MS_L_MAX) begin
      w_nsl = 4'd0;
      if (r_sh == MS_H_MAX) begin
        w_nsh = 4'd0;
        if (r_ml == MS_L_MAX) begin
          w_nml = 4'd0;
          if (r_mh == MS_H_MAX) begin
            w_nmh = 4'd0;
            if (r_hh == HH_MAX && r_hl == HL_MAX_H2) begin
              w_nhh = 4'd0;
              w_nhl = 4'd0;
            end else if (r_hl == HL_MAX) begin
              w_nhl = 4'd0;
              w_nhh = r_hh + 4'd1;
            end else begin
              w_nhl = r_hl + 4'd1;
            end
          end else w_nmh = r_mh + 4'd1;
        end else w_nml = r_ml + 4'd1;
      end else w_nsh = r_sh + 4'd1;
    end else w_nsl = r_sl + 4'd1;
  end

  // Time registers: tick advance or per-digit key edit (never both, set gates the tick)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_hh, r_hl, r_mh, r_ml, r_sh, r_sl} <= '0;
    end else if (w_tick) begin
      {r_hh, r_hl, r_mh, r_ml, r_sh, r_sl} <= {w_nhh, w_nhl, w_nmh, w_nml, w_nsh, w_nsl};
    end else if (w_edit_t) begin
      case (w_key_code)
        KEY_HH:  {r_hh, r_hl} <= inc_hour_h(r_hh, r_hl);
        KEY_HL:  r_hl <= inc_hour_l(r_hh, r_hl);
        KEY_MH:  r_mh <= wrap_inc(r_mh, MS_H_MAX);
        KEY_ML:  r_ml <= wrap_inc(r_ml, MS_L_MAX);
        KEY_SH:  r_sh <= wrap_inc(r_sh, MS_H_MAX);
        KEY_SL:  r_sl <= wrap_inc(r_sl, MS_L_MAX);
        default: ;
      endcase
    end
  end

  // Alarm HH:MM registers; seconds keys have no alarm target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_ahh, r_ahl, r_amh, r_aml} <= '0;
    end else if (w_edit_a) begin
      case (w_key_code)
        KEY_HH:  {r_ahh, r_ahl} <= inc_hour_h(r_ahh, r_ahl);
        KEY_HL:  r_ahl <= inc_hour_l(r_ahh, r_ahl);
        KEY_MH:  r_amh <= wrap_inc(r_amh, MS_H_MAX);
        KEY_ML:  r_aml <= wrap_inc(r_aml, MS_L_MAX);
        default: ;
      endcase
    end
  end

  // Alarm enable toggles from the keypad in any mode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_alen <= 1'b0;
    else if (w_alen_tog) r_alen <= ~r_alen;
  end

  // Ring control: trigger beats dismiss/disable; times out after RING_SECS ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm <= 1'b0;
      r_ring  <= '0;
    end else if (w_trig) begin
      r_alarm <= 1'b1;
      r_ring  <= RW'(RING_SECS);
    end else if (!r_alen || w_alen_tog || w_dismiss) begin
      r_alarm <= 1'b0;
      r_ring  <= '0;
    end else if (w_tick && r_alarm) begin
      if (r_ring <= RW'(1)) begin
        r_alarm <= 1'b0;
        r_ring  <= '0;
      end else begin
        r_ring <= r_ring - 1'b1;
      end
    end
  end

  assign alarm_out = r_alarm;

  // ---------------- display ----------------
  logic [SW-1:0] r_scan;
  logic [2:0]    w_pos, r_pos;
  logic          w_show_alarm, w_pm, r_pm;
  logic [3:0]    w_dhh, w_dhl, w_d0, w_d1, w_d4, w_d5, w_dig;
  logic [4:0]    w_hbin, w_h12;
  logic [5:0]    r_sel;
  logic [6:0]    r_seg;

  assign w_pos        = r_scan[SW-1:SCAN_SHIFT];
  assign w_show_alarm = set && alarm_set;
  assign w_dhh        = w_show_alarm ? r_ahh : r_hh;
  assign w_dhl        = w_show_alarm ? r_ahl : r_hl;
  assign w_hbin       = 5'(w_dhh) * 5'd10 + 5'(w_dhl);
  assign w_h12        = (w_hbin == 5'd0) ? 5'd12 : (w_hbin > 5'd12) ? w_hbin - 5'd12 : w_hbin;
  assign w_pm         = mode_12h && (w_hbin >= 5'd12);
  assign w_d4         = w_show_alarm ? BLANK : r_sh;
  assign w_d5         = w_show_alarm ? BLANK : r_sl;

  // Hour digits: raw BCD in 24h mode, converted with leading-zero blank in 12h mode
  always_comb begin
    w_d0 = w_dhh;
    w_d1 = w_dhl;
    if (mode_12h) begin
      w_d0 = (w_h12 >= 5'd10) ? 4'd1 : BLANK;
      w_d1 = (w_h12 >= 5'd10) ? 4'(w_h12 - 5'd10) : 4'(w_h12);
    end
  end

  // Digit mux for the position selected in the previous cycle
  always_comb begin
    case (r_pos)
      3'd0:    w_dig = w_d0;
      3'd1:    w_dig = w_d1;
      3'd2:    w_dig = r_show_mh();
      3'd3:    w_dig = r_show_ml();
      3'd4:    w_dig = w_d4;
      3'd5:    w_dig = w_d5;
      default: w_dig = BLANK;
    endcase
  end

  function automatic logic [3:0] r_show_mh();
    r_show_mh = w_show_alarm ? r_amh : r_mh;
  endfunction

  function automatic logic [3:0] r_show_ml();
    r_show_ml = w_show_alarm ? r_aml : r_ml;
  endfunction

  // Free-running scan; select registered from the counter, segments one cycle behind
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan <= '0;
      r_pos  <= 3'd7;
      r_sel  <= 6'b111111;
      r_seg  <= 7'b0;
      r_pm   <= 1'b0;
    end else begin
      r_scan <= r_scan + 1'b1;
      r_pos  <= w_pos;
      r_sel  <= (w_pos < 3'd6) ? ~(6'b100000 >> w_pos) : 6'b111111;
      r_seg  <= seg7(w_dig);
      r_pm   <= w_pm;
    end
  end

  assign num0_scan_select = r_sel;
  assign num0_seg7        = r_seg;
  assign pm_led           = r_pm;

endmodule

// File: tb/tb_watch_alarm.sv
// Directed bench for watch_alarm with a key-event scoreboard and a matrix model.
module tb_watch_alarm;

  logic       clk = 1'b0, reset = 1'b0, set = 1'b0, alarm_set = 1'b0, mode_12h = 1'b0;
  logic [3:0] key_row, key_col;
  logic [5:0] num0_scan_select;
  logic [6:0] num0_seg7;
  logic       pm_led, alarm_out;

  logic       pressed = 1'b0;
  int         p_row = 0, p_col = 0;
  int         n_chk = 0, n_fail = 0, n_kv = 0;
  logic [3:0] exp_q[$];
  logic [6:0] got_seg[6];

  watch_alarm #(.TICK_DIV(10), .SCAN_SHIFT(2), .DEB_CYCLES(4), .RING_SECS(3)) dut (
    .clk(clk), .reset(reset), .set(set), .alarm_set(alarm_set), .mode_12h(mode_12h),
    .key_row(key_row), .key_col(key_col), .num0_scan_select(num0_scan_select),
    .num0_seg7(num0_seg7), .pm_led(pm_led), .alarm_out(alarm_out)
  );

  always #5 clk = ~clk;

  // Pressed switch connects its row to its column
  assign key_row = (pressed && !key_col[p_col]) ? ~(4'b0001 << p_row) : 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] tseg(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [23:0] tbcd();
    return {dut.r_hh, dut.r_hl, dut.r_mh, dut.r_ml, dut.r_sh, dut.r_sl};
  endfunction

  // Scoreboard: every key event pops the oldest expected code
  always @(negedge clk) begin
    if (dut.w_key_valid === 1'b1) begin
      n_kv++;
      if (exp_q.size() == 0) chk("spurious_key", exp_q.size(), 1);
      else                   chk("key_code", dut.w_key_code, exp_q.pop_front());
    end
  end

  task automatic press(input int row, input int col);
    int t;
    exp_q.push_back(4'(col * 4 + row));
    p_row = row; p_col = col; pressed = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) begin chk("key_timeout", exp_q.size(), 0); exp_q.delete(); end
    pressed = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_tick();
    int t;
    t = 0;
    while (dut.w_tick !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk("tick_timeout", t, 0);
    @(posedge clk); #1;
  endtask

  task automatic read_disp();
    logic [5:0] prev, got;
    int t;
    got = '0; prev = 6'h3F; t = 0;
    while (got != 6'h3F && t < 100) begin
      @(negedge clk); t++;
      for (int i = 0; i < 6; i++)
        if (num0_scan_select == ~(6'b100000 >> i) && prev == num0_scan_select) begin
          got_seg[i] = num0_seg7; got[i] = 1'b1;
        end
      prev = num0_scan_select;
    end
    if (got != 6'h3F) chk("disp_timeout", got, 6'h3F);
  endtask

  task automatic chk_disp(input string tag, input int a, input int b, input int c,
                          input int d, input int e, input int f);
    int ex[6];
    ex = '{a, b, c, d, e, f};
    read_disp();
    for (int i = 0; i < 6; i++) chk($sformatf("%s_d%0d", tag, i), got_seg[i], tseg(ex[i]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, key_col, 4'b0000);
    chk({tag, "_alarm"}, alarm_out, 1'b0);
    chk({tag, "_pm"}, pm_led, 1'b0);
    chk({tag, "_seg"}, num0_seg7, 7'd0);
    chk({tag, "_sel"}, num0_scan_select, 6'b111111);
    chk({tag, "_time"}, tbcd(), 24'h0);
    chk({tag, "_alen"}, dut.r_alen, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t, bad, kv0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // preload 23:59:59 and roll over
    set = 1'b1;
    repeat (2) press(1, 0);
    repeat (3) press(1, 1);
    repeat (5) press(2, 0);
    repeat (9) press(2, 1);
    repeat (5) press(3, 0);
    repeat (9) press(3, 1);
    chk("preload", tbcd(), 24'h235959);
    set = 1'b0;
    wait_tick();
    chk("rollover", tbcd(), 24'h000000);
    set = 1'b1;
    chk_disp("roll", 0, 0, 0, 0, 0, 0);

    // long hold on hour_l+: one event, divider frozen
    kv0 = n_kv; bad = 0;
    exp_q.push_back(4'd5); p_row = 1; p_col = 1; pressed = 1'b1;
    repeat (20) begin @(negedge clk); if (dut.r_tick_cnt != 0) bad++; end
    pressed = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_events", n_kv - kv0, 1);
    chk("hold_time", tbcd(), 24'h010000);
    chk("hold_tick0", bad, 0);

    // hour_h into 2 clamps hour_l, then hour_l wraps at 3
    repeat (8) press(1, 1);
    chk("hl9", tbcd(), 24'h090000);
    press(1, 0);
    chk("hh1", tbcd(), 24'h190000);
    press(1, 0);
    chk("hh2_clamp", tbcd(), 24'h230000);
    press(1, 1);
    chk("hl_wrap3", tbcd(), 24'h200000);

    // bounce shorter than debounce
    kv0 = n_kv;
    p_row = 0; p_col = 0; pressed = 1'b1;
    repeat (3) @(negedge clk);
    pressed = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_events", n_kv - kv0, 0);
    chk("bounce_col", key_col, 4'b0000);

    // alarm 00:01, time 00:00:59, ring for three ticks
    do_reset();
    set = 1'b1; alarm_set = 1'b1;
    press(2, 1);
    chk_disp("alm", 0, 0, 0, 1, 15, 15);
    alarm_set = 1'b0;
    repeat (5) press(3, 0);
    repeat (9) press(3, 1);
    press(1, 2);
    chk("alen_on", dut.r_alen, 1'b1);
    set = 1'b0;
    wait_tick();
    chk("ring_on", alarm_out, 1'b1);
    wait_tick(); chk("ring_t1", alarm_out, 1'b1);
    wait_tick(); chk("ring_t2", alarm_out, 1'b1);
    wait_tick(); chk("ring_off", alarm_out, 1'b0);

    // re-arm for 00:02 and dismiss from the keypad
    set = 1'b1; alarm_set = 1'b1;
    press(2, 1);
    alarm_set = 1'b0;
    repeat (5) press(3, 0);
    repeat (6) press(3, 1);
    chk("pre_dismiss", tbcd(), 24'h000159);
    set = 1'b0;
    wait_tick();
    chk("ring_on2", alarm_out, 1'b1);
    exp_q.push_back(4'd10); p_row = 2; p_col = 2; pressed = 1'b1;
    t = 0;
    while (dut.w_key_valid !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) chk("dismiss_timeout", t, 0);
    chk("ring_at_kv", alarm_out, 1'b1);
    @(posedge clk); #1;
    chk("dismissed", alarm_out, 1'b0);
    pressed = 1'b0;
    repeat (12) @(negedge clk);

    // 13:05:00 in 12h and 24h display
    do_reset();
    set = 1'b1;
    press(1, 0);
    repeat (3) press(1, 1);
    repeat (5) press(2, 1);
    mode_12h = 1'b1;
    chk_disp("h12", 15, 1, 0, 5, 0, 0);
    chk("pm12", pm_led, 1'b1);
    mode_12h = 1'b0;
    chk_disp("h24", 1, 3, 0, 5, 0, 0);
    chk("pm24", pm_led, 1'b0);

    // asynchronous reset while the scanner is driving a column
    p_row = 0; p_col = 3; pressed = 1'b1;
    t = 0;
    while (key_col == 4'b0000 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk("scan_timeout", t, 0);
    #2 reset = 1'b0;
    #1 chk_reset("rst_scan");
    pressed = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
